sc_fir_seq_accum: RTL and testbench
===================================

Name: sc_fir_seq_accum

Overview:
- Parametrised stochastic-computing FIR output stage.
- Converts binary tap inputs to stochastic bits with a comparator against an internal LFSR, applies per-tap sign by XOR, and picks one tap per cycle by programmable coefficient weight.
- Counts ones over a full 2^N-cycle stochastic sequence and reports the count with a start/done handshake.
- Successor to the fixed-mux-tree accumulators: taps, precision, weights and folding are programmable, and it owns its sequence counter and RNG.

Parameters:
- N, 10, stochastic precision; sequence length 2^N; width of x and rng.
- TAPS, 20, number of weighted taps (2 or more).
- FOLD, 1, 1 = symmetric folding: seq MSB selects the mirrored input half.
- M, N-FOLD, weight resolution in bits; coefficient magnitudes sum to 2^M.
- SEED, 1, LFSR reload value; must be nonzero.

Ports:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- start  in  1  single-cycle pulse; sampled in IDLE or DONE
- x  in  [N-1:0] x[TAPS*(1+FOLD)-FOLD]  binary inputs; the mirrored half is used when FOLD=1
- coef_mag  in  [M:0] coef_mag[TAPS]  weight magnitudes; sampled at start
- coef_sign  in  TAPS  1 = negative coefficient (stochastic bit inverted); sampled at start
- busy  out  1  high in RUN
- result_valid  out  1  high in DONE
- result  out  N+1  ones count, range 0..2^N
- cfg_err  out  1  sum of coef_mag at start differs from 2^M

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high. Reset forces state IDLE, seq=0, acc=0, lfsr=SEED, result=0, busy=0, result_valid=0, cfg_err=0, and aborts any run with no result.
- States:
  - IDLE to RUN on start.
  - RUN to DONE after 2^N RUN cycles.
  - DONE to RUN on start. Otherwise DONE holds; result and result_valid stay stable.
- Start behaviour:
  - At a start edge: latch coef_mag and coef_sign, compute cfg_err, clear seq and acc, reload lfsr=SEED.
  - result_valid drops the cycle after start in DONE.
  - start during RUN is ignored.
- Run timing:
  - Each RUN cycle accumulates exactly one bit.
  - After the last RUN cycle, result = final acc and state = DONE.
  - result_valid rises 2^N+1 edges after the start edge.
  - x is sampled live every RUN cycle and must be held stable by the producer.
- Per-cycle datapath in RUN, all combinational into acc:
  - s = bit-reverse of seq[M-1:0]. Bit reversal spreads each weight evenly over the sequence.
  - Cumulative sums C[0]=0, C[t+1]=C[t]+coef_mag[t], each M+1 bits plus guard bits.
  - Selected tap = the t with C[t] <= s < C[t+1]. Zero-weight taps are never selected.
  - If no tap matches (sum < 2^M), the bit is 0.
  - If sum > 2^M, only the taps below 2^M participate.
  - Input index: with FOLD=0, use t. With FOLD=1, use t when seq[N-1]=0, else 2*TAPS-2-t.
  - Stochastic bit = (x[idx] > lfsr), strict unsigned compare, XOR coef_sign[t].
  - acc += bit. acc is N+1 bits and never wraps; its maximum is 2^N.
- LFSR:
  - N-bit maximal-length Galois, taps taken from the package table, advancing every RUN cycle.
  - Never takes the value 0, so x=0 always gives bit 0 and x=2^N-1 gives 0 only when lfsr = 2^N-1.
- seq:
  - N-bit counter, incremented every RUN cycle.
  - The terminal RUN cycle is seq == 2^N-1, detected on that cycle.
- cfg_err:
  - Registered at the start edge and held until the next start or reset.
  - It does not stop the run.

Decomposition:
- Package sc_fir_pkg:
  - LFSR tap-mask function indexed by N (supporting 4..16).
  - State enum {IDLE, RUN, DONE}.
  - Bit-reverse function.
- Sub-module sc_lfsr:
  - Ports clock, reset, load, en, q.
  - Parameters N, SEED.
  - Reused by the sibling SC blocks.
- Tap selection and compare stay in this module as a generate loop.

Test Plan:
- Bench settings: N=4, TAPS=4, FOLD=0, M=4.
- x all 0, coef_mag {16,0,0,0}, signs 0, start -> busy for 16 cycles, result_valid at edge 17, result=0, cfg_err=0.
- Same, coef_sign=4'b1111 -> result=16, which checks the no-wrap N+1 width.
- coef_mag {4,4,4,4}, x={0,0,15,15}, signs 0 -> result equals the reference-model count. Check selection pattern s=bitrev(seq): each tap is chosen exactly 4 times.
- coef_mag {8,4,0,0} (sum 12) -> cfg_err=1; the 4 cycles with s>=12 contribute 0 (check with x all 15, signs 1). A following valid start clears cfg_err.
- start pulse at run cycle 5 -> ignored, and done timing is unchanged. start in DONE -> result_valid low the next cycle and a new run begins.
- reset asserted asynchronously mid-run (cycle 7) -> outputs zero immediately, state IDLE; a new start gives the full 16-cycle run with result equal to the clean-run value.

Source files
------------

// File: rtl/sc_fir_pkg.sv
// Shared definitions for the stochastic-computing FIR blocks: FSM states,
// Galois LFSR tap masks and a bit-reversal helper.
package sc_fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Right-shifting Galois masks for maximal-length sequences, widths 4..16.
    function automatic logic [15:0] lfsr_mask(input int n);
        logic [15:0] m;
        case (n)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    // Reverses the low w bits of v; bits at w and above come back as zero.
    function automatic logic [15:0] bit_rev(input logic [15:0] v, input int w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// N-bit maximal-length Galois LFSR with synchronous reload to SEED.
module sc_lfsr
    import sc_fir_pkg::*;
#(
    parameter int          N    = 10,
    parameter int unsigned SEED = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    output logic [N-1:0] q
);

    localparam logic [N-1:0] MASK   = N'(lfsr_mask(N));
    localparam logic [N-1:0] SEED_V = N'(SEED);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= SEED_V;
        end else if (load) begin
            q <= SEED_V;
        end else if (en) begin
            q <= q[0] ? ((q >> 1) ^ MASK) : (q >> 1);
        end
    end

endmodule

// File: rtl/sc_fir_seq_accum.sv
// Stochastic FIR output stage: one weighted tap per cycle is compared against
// the LFSR, sign-adjusted and counted over a full 2^N-cycle sequence.
//
// state | meaning
// IDLE  | waiting for start, no result yet
// RUN   | accumulating one stochastic bit per cycle, 2^N cycles
// DONE  | result valid and held until the next start
module sc_fir_seq_accum
    import sc_fir_pkg::*;
#(
    parameter int          N    = 10,
    parameter int          TAPS = 20,
    parameter int          FOLD = 1,
    parameter int          M    = N - FOLD,
    parameter int unsigned SEED = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [N-1:0]        x [TAPS*(1+FOLD)-FOLD],
    input  logic [M:0]          coef_mag [TAPS],
    input  logic [TAPS-1:0]     coef_sign,
    output logic                busy,
    output logic                result_valid,
    output logic [N:0]          result,
    output logic                cfg_err
);

    localparam int             CW       = M + 1 + $clog2(TAPS);
    localparam logic [CW-1:0]  FULL     = CW'(1) << M;
    localparam logic [N-1:0]   SEQ_LAST = '1;

    state_t          state, state_nx;
    logic            go, run, last, sc_bit;
    logic [N-1:0]    seq, lfsr;
    logic [N:0]      acc;
    logic [M:0]      mag_q [TAPS];
    logic [TAPS-1:0] sign_q, tap_bit;
    logic [CW-1:0]   csum [TAPS+1];
    logic [CW-1:0]   live_sum;
    logic [M-1:0]    s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        go       = 1'b0;
        run      = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    go       = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                run = 1'b1;
                if (seq == SEQ_LAST) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    go       = 1'b1;
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy         = (state == RUN);
    assign result_valid = (state == DONE);

    always_comb begin
        live_sum = '0;
        csum[0]  = '0;
        for (int t = 0; t < TAPS; t++) begin
            live_sum  = live_sum + CW'(coef_mag[t]);
            csum[t+1] = csum[t] + CW'(mag_q[t]);
        end
    end

    // Bit reversal of the sequence index spreads each weight evenly in time.
    assign s = M'(bit_rev(16'(seq), M));

    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        logic         hit;
        logic [N-1:0] xin;
        if (FOLD != 0) begin : g_fold
            assign xin = seq[N-1] ? x[2*TAPS-2-t] : x[t];
        end else begin : g_flat
            assign xin = x[t];
        end
        // Intervals are disjoint and end below 2^M, so at most one tap hits.
        assign hit        = (csum[t] <= CW'(s)) && (CW'(s) < csum[t+1]);
        assign tap_bit[t] = hit & ((xin > lfsr) ^ sign_q[t]);
    end

    assign sc_bit = |tap_bit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq     <= '0;
            acc     <= '0;
            result  <= '0;
            cfg_err <= 1'b0;
            sign_q  <= '0;
            for (int t = 0; t < TAPS; t++) mag_q[t] <= '0;
        end else if (go) begin
            seq     <= '0;
            acc     <= '0;
            mag_q   <= coef_mag;
            sign_q  <= coef_sign;
            cfg_err <= (live_sum != FULL);
        end else if (run) begin
            seq <= seq + 1'b1;
            acc <= acc + (N+1)'(sc_bit);
            if (last) result <= acc + (N+1)'(sc_bit);
        end
    end

    sc_lfsr #(
        .N    (N),
        .SEED (SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .load  (go),
        .en    (run),
        .q     (lfsr)
    );

endmodule

// File: tb/tb_sc_fir_seq_accum.sv
// Directed bench for sc_fir_seq_accum at N=4, TAPS=4, FOLD=0, M=4 with
// hand-computed counts based on the seed-1 LFSR sequence.
module tb_sc_fir_seq_accum;

    localparam int N    = 4;
    localparam int TAPS = 4;
    localparam int FOLD = 0;
    localparam int M    = 4;

    logic            clock;
    logic            reset;
    logic            start;
    logic [N-1:0]    x [TAPS];
    logic [M:0]      coef_mag [TAPS];
    logic [TAPS-1:0] coef_sign;
    logic            busy;
    logic            result_valid;
    logic [N:0]      result;
    logic            cfg_err;

    int total = 0;
    int bad   = 0;

    sc_fir_seq_accum #(
        .N    (N),
        .TAPS (TAPS),
        .FOLD (FOLD),
        .M    (M),
        .SEED (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .x            (x),
        .coef_mag     (coef_mag),
        .coef_sign    (coef_sign),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .cfg_err      (cfg_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int m0, input int m1, input int m2, input int m3,
                           input int x0, input int x1, input int x2, input int x3,
                           input logic [TAPS-1:0] sg);
        coef_mag[0] = 5'(m0);
        coef_mag[1] = 5'(m1);
        coef_mag[2] = 5'(m2);
        coef_mag[3] = 5'(m3);
        x[0] = 4'(x0);
        x[1] = 4'(x1);
        x[2] = 4'(x2);
        x[3] = 4'(x3);
        coef_sign = sg;
    endtask

    // Start edge counts as edge 1; done_edge is the edge after which DONE is seen.
    task automatic run_seq(input int mid_start, output int done_edge, output int busy_cnt);
        done_edge = 0;
        busy_cnt  = 0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (i == 0) begin
                check("rv_low_after_start", 32'(result_valid), 0);
                check("busy_after_start", 32'(busy), 1);
            end
            if (result_valid) begin
                done_edge = i + 1;
                break;
            end
            if (busy) busy_cnt++;
            start = (i == mid_start);
        end
        start = 1'b0;
    endtask

    int de, bc;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_cfg(16, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        #23;
        check("rst_busy", 32'(busy), 0);
        check("rst_rv", 32'(result_valid), 0);
        check("rst_result", 32'(result), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        reset = 1'b0;

        // x all zero, single full-weight tap: no ones.
        run_seq(-1, de, bc);
        check("t1_done_edge", 32'(de), 17);
        check("t1_busy_cycles", 32'(bc), 16);
        check("t1_result", 32'(result), 0);
        check("t1_cfg_err", 32'(cfg_err), 0);

        // Negative sign inverts every bit: full count of 16, started from DONE.
        set_cfg(16, 0, 0, 0, 0, 0, 0, 0, 4'b1111);
        run_seq(-1, de, bc);
        check("t2_result", 32'(result), 16);
        check("t2_done_edge", 32'(de), 17);

        // Equal weights; tap 2 meets lfsr=15 on seq 9.
        set_cfg(4, 4, 4, 4, 0, 0, 15, 15, 4'b0000);
        run_seq(-1, de, bc);
        check("t3_result", 32'(result), 7);

        // One hot tap at a time shows each tap selected on four cycles.
        set_cfg(4, 4, 4, 4, 15, 0, 0, 0, 4'b0000);
        run_seq(-1, de, bc);
        check("t3_tap0", 32'(result), 4);
        set_cfg(4, 4, 4, 4, 0, 15, 0, 0, 4'b0000);
        run_seq(-1, de, bc);
        check("t3_tap1", 32'(result), 4);
        set_cfg(4, 4, 4, 4, 0, 0, 15, 0, 4'b0000);
        run_seq(-1, de, bc);
        check("t3_tap2", 32'(result), 3);
        set_cfg(4, 4, 4, 4, 0, 0, 0, 15, 4'b0000);
        run_seq(-1, de, bc);
        check("t3_tap3", 32'(result), 4);

        // Sum 12: s>=12 contributes 0; only seq 9 (lfsr=15) yields a one.
        set_cfg(8, 4, 0, 0, 15, 15, 15, 15, 4'b1111);
        run_seq(-1, de, bc);
        check("t4_cfg_err", 32'(cfg_err), 1);
        check("t4_result", 32'(result), 1);

        // Async reset mid-run clears outputs immediately.
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (7) @(negedge clock);
        check("t5_busy_before", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_rv", 32'(result_valid), 0);
        check("t5_rst_result", 32'(result), 0);
        check("t5_rst_cfg_err", 32'(cfg_err), 0);
        #3 reset = 1'b0;
        run_seq(-1, de, bc);
        check("t5_rerun_result", 32'(result), 1);
        check("t5_rerun_edge", 32'(de), 17);
        check("t5_rerun_cfg_err", 32'(cfg_err), 1);

        // Valid config clears cfg_err; start during RUN is ignored.
        set_cfg(4, 4, 4, 4, 0, 0, 15, 15, 4'b0000);
        run_seq(5, de, bc);
        check("t6_cfg_err", 32'(cfg_err), 0);
        check("t6_done_edge", 32'(de), 17);
        check("t6_busy_cycles", 32'(bc), 16);
        check("t6_result", 32'(result), 7);

        // Sum 24: tap 1 sits above 2^M and never participates.
        set_cfg(16, 8, 0, 0, 15, 15, 15, 15, 4'b0010);
        run_seq(-1, de, bc);
        check("t7_cfg_err", 32'(cfg_err), 1);
        check("t7_result", 32'(result), 15);

        // DONE holds without start.
        repeat (5) @(negedge clock);
        check("t8_hold_rv", 32'(result_valid), 1);
        check("t8_hold_result", 32'(result), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
